// File: rtl/axis_fifo_pkg.sv
// Shared helpers for the AXI-Stream synchronous FIFO: pointer sizing and level comparison.
package axis_fifo_pkg;

  // The extra MSB lets a full FIFO be told apart from an empty one.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic level_ge(input int unsigned level, input int unsigned thresh);
    return level >= thresh;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH register file: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module sync_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock FWFT FIFO with AXI-Stream handshakes, occupancy level and almost flags.
// Define AXIS_SYNC_FIFO_PACKET_EN to add tlast and hold output until a whole packet is stored.
module axis_sync_fifo
  import axis_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_s_tvalid,
  input  logic [WIDTH-1:0]         i_s_tdata,
`ifdef AXIS_SYNC_FIFO_PACKET_EN
  input  logic                     i_s_tlast,
  output logic                     o_m_tlast,
`endif
  output logic                     o_s_tready,
  output logic                     o_m_tvalid,
  output logic [WIDTH-1:0]         o_m_tdata,
  input  logic                     i_m_tready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_almost_full,
  output logic                     o_almost_empty
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned AW = PW - 1;
`ifdef AXIS_SYNC_FIFO_PACKET_EN
  localparam int unsigned MW = WIDTH + 1;
`else
  localparam int unsigned MW = WIDTH;
`endif

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] level;
  logic          push, pop;
  logic [MW-1:0] wdata, rdata;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign o_level = level;
  assign o_full  = (level == PW'(DEPTH));
  assign o_empty = (level == '0);

  assign o_almost_full  = level_ge(32'(level), AF_THRESH);
  assign o_almost_empty = !level_ge(32'(level), AE_THRESH + 1);

  // Ready depends only on stored state, never on the downstream ready.
  assign o_s_tready = !o_full;

  assign push = i_s_tvalid && o_s_tready;
  assign pop  = o_m_tvalid && i_m_tready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

`ifdef AXIS_SYNC_FIFO_PACKET_EN
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          pkt_in, pkt_out;

  assign wdata     = {i_s_tlast, i_s_tdata};
  assign o_m_tdata = rdata[WIDTH-1:0];
  assign o_m_tlast = rdata[WIDTH];

  assign pkt_in  = push && i_s_tlast;
  assign pkt_out = pop && o_m_tlast;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    unique case ({pkt_in, pkt_out})
      2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
      2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // Releasing on full lets a packet longer than DEPTH cut through instead of deadlocking.
  assign o_m_tvalid = !o_empty && ((pkt_cnt_q != '0) || o_full);
`else
  assign wdata      = i_s_tdata;
  assign o_m_tdata  = rdata;
  assign o_m_tvalid = !o_empty;
`endif

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (MW),
    .AW    (AW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (push && !i_rst),
    .i_waddr (wr_ptr_q[AW-1:0]),
    .i_wdata (wdata),
    .i_raddr (rd_ptr_q[AW-1:0]),
    .o_rdata (rdata)
  );

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Scoreboard bench for axis_sync_fifo (DEPTH=8, WIDTH=8, AF=6, AE=2).
module tb_axis_sync_fifo;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_tvalid;
  logic [7:0] s_tdata;
  logic       s_tlast;
  logic       s_tready;
  logic       m_tvalid;
  logic [7:0] m_tdata;
  logic       m_tlast;
  logic       m_tready;
  logic [3:0] level;
  logic       full, empty, af, ae;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q [$];
  bit         pop_pending  = 1'b0;
  bit         last_push_ok = 1'b0;

  always #5 clk = ~clk;

  axis_sync_fifo #(
    .DEPTH     (DEPTH),
    .WIDTH     (8),
    .AF_THRESH (6),
    .AE_THRESH (2)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_s_tvalid     (s_tvalid),
    .i_s_tdata      (s_tdata),
`ifdef AXIS_SYNC_FIFO_PACKET_EN
    .i_s_tlast      (s_tlast),
    .o_m_tlast      (m_tlast),
`endif
    .o_s_tready     (s_tready),
    .o_m_tvalid     (m_tvalid),
    .o_m_tdata      (m_tdata),
    .i_m_tready     (m_tready),
    .o_level        (level),
    .o_full         (full),
    .o_empty        (empty),
    .o_almost_full  (af),
    .o_almost_empty (ae)
  );

`ifndef AXIS_SYNC_FIFO_PACKET_EN
  assign m_tlast = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_tvalid();
    int n = 0;
    if (exp_q.size() == 0) return 1'b0;
    foreach (exp_q[i]) if (exp_q[i][8]) n++;
`ifdef AXIS_SYNC_FIFO_PACKET_EN
    return (n != 0) || (exp_q.size() == DEPTH);
`else
    return 1'b1;
`endif
  endfunction

  // Expected-state model: enqueue accepted pushes, retire pops flagged by the monitor.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      last_push_ok = 1'b0;
    end else begin
      last_push_ok = s_tvalid && (exp_q.size() < DEPTH);
      if (pop_pending) void'(exp_q.pop_front());
      if (last_push_ok) exp_q.push_back({s_tlast, s_tdata});
    end
    pop_pending = 1'b0;
  end

  // Monitor: compare status and the head word away from the active edge.
  initial forever begin
    int sz;
    @(negedge clk);
    sz = exp_q.size();
    chk("level", 32'(level), sz);
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("s_tready", 32'(s_tready), 32'(sz != DEPTH));
    chk("almost_full", 32'(af), 32'(sz >= 6));
    chk("almost_empty", 32'(ae), 32'(sz <= 2));
    chk("m_tvalid", 32'(m_tvalid), 32'(model_tvalid()));
    if (!rst && model_tvalid() && m_tready) begin
      chk("m_tdata", 32'(m_tdata), 32'(exp_q[0][7:0]));
`ifdef AXIS_SYNC_FIFO_PACKET_EN
      chk("m_tlast", 32'(m_tlast), 32'(exp_q[0][8]));
`endif
      pop_pending = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    m_tready = 1'b1;
    for (int i = 0; i < 40 && !empty; i++) step();
    chk(name, 32'(empty), 32'd1);
    m_tready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b1; m_tready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_tready", 32'(s_tready), 32'd1);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_ae", 32'(ae), 32'd1);

    // Fill without draining; almost_full first at level 6.
    for (int i = 0; i < 8; i++) begin
      s_tvalid = 1'b1; s_tdata = 8'(i + 1);
      step();
      chk("fill_level", 32'(level), 32'(i + 1));
      chk("fill_af", 32'(af), 32'((i + 1) >= 6));
    end
    chk("fill_full", 32'(full), 32'd1);
    s_tdata = 8'h09;
    step();
    chk("ninth_level", 32'(level), 32'd8);
    chk("ninth_tready", 32'(s_tready), 32'd0);

    // Continuous ramp from full: first edge only pops, afterwards push+pop each edge.
    m_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("ramp_level", 32'(level), 32'd7);
      if (last_push_ok) s_tdata = s_tdata + 8'd1;
    end
    s_tvalid = 1'b0;
    drain("ramp_drain");

    // FWFT latency from empty.
    s_tvalid = 1'b1; s_tdata = 8'hA5;
    step();
    s_tvalid = 1'b0;
    chk("fwft_tvalid", 32'(m_tvalid), 32'd1);
    chk("fwft_tdata", 32'(m_tdata), 32'hA5);
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    chk("fwft_empty", 32'(empty), 32'd1);

    // Reset mid-transfer discards contents and ignores the handshake.
    for (int i = 0; i < 5; i++) begin
      s_tvalid = 1'b1; s_tdata = 8'(8'h11 + i);
      step();
    end
    chk("pre_rst_level", 32'(level), 32'd5);
    rst = 1'b1; s_tdata = 8'h99; m_tready = 1'b1;
    step();
    rst = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
    s_tvalid = 1'b1; s_tdata = 8'h3C;
    step();
    s_tvalid = 1'b0;
    chk("post_rst_tdata", 32'(m_tdata), 32'h3C);
    drain("post_rst_drain");

`ifdef AXIS_SYNC_FIFO_PACKET_EN
    // Output held until a full packet is stored.
    s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = 8'h21;
    step();
    chk("pkt_hold1", 32'(m_tvalid), 32'd0);
    s_tdata = 8'h22;
    step();
    chk("pkt_hold2", 32'(m_tvalid), 32'd0);
    s_tlast = 1'b1; s_tdata = 8'h23;
    step();
    chk("pkt_release", 32'(m_tvalid), 32'd1);
    s_tvalid = 1'b0;
    drain("pkt_drain");

    // Oversized packet: cut-through release once full.
    s_tlast = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_tvalid = 1'b1; s_tdata = 8'(8'h30 + i);
      step();
      chk("cut_tvalid", 32'(m_tvalid), 32'(i == 7));
    end
    s_tlast = 1'b1; s_tdata = 8'h40; m_tready = 1'b1;
    step();
    chk("cut_level", 32'(level), 32'd7);
    chk("cut_hold", 32'(m_tvalid), 32'd0);
    step();
    s_tvalid = 1'b0;
    chk("cut_end_level", 32'(level), 32'd8);
    drain("cut_drain");
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
